// File: rtl/pipeline_ctrl.sv
// Stage-sequencing controller for the IF/ID/EX/WB core: stalls the pipe for
// LSU transactions, squashes wrong-path work on taken branches, halts on LSU timeout.
//
// state    | meaning
// RUN      | normal issue; detects memory ops and taken branches in EX
// MEM_REQ  | LSU request held high until accepted
// MEM_RESP | request accepted, waiting for the LSU response
// HALT     | LSU timed out; pipe frozen until reset
module pipeline_ctrl #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ifu_valid,
  input  logic       ifu_busy,
  input  logic       EX_MemRd,
  input  logic       EX_MemWr,
  input  logic       EX_BranchTaken,
  input  logic       lsu_req_ready,
  input  logic       lsu_resp_valid,
  output logic       PC_Wr,
  output logic       IDReg_Wr,
  output logic       EXReg_Wr,
  output logic       WBReg_Wr,
  output logic       IDReg_Flush,
  output logic       EXReg_Flush,
  output logic       WBReg_Flush,
  output logic       ifu_ack,
  output logic       lsu_req_valid,
  output logic       timeout_err,
  output logic [1:0] ctrl_state
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_RESP = 2'd2,
    HALT     = 2'd3
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nxt;
  logic        r_drop_pending;
  logic        w_drop_nxt;
  logic        r_timeout_err;
  logic        w_terr_nxt;

  logic        w_cnt_last;
  logic [15:0] w_cnt_inc;

  // Fetch-side outcome, used wherever EX advances
  logic        w_f_pc_wr;
  logic        w_f_id_wr;
  logic        w_f_id_flush;
  logic        w_f_ack;
  logic        w_f_drop_nxt;

  logic        w_pc_wr;
  logic        w_id_wr;
  logic        w_ex_wr;
  logic        w_wb_wr;
  logic        w_id_flush;
  logic        w_ex_flush;
  logic        w_wb_flush;
  logic        w_ack;
  logic        w_lsu_req;

  assign w_cnt_last = (r_cnt == CNT_LAST);
  assign w_cnt_inc  = w_cnt_last ? r_cnt : r_cnt + 16'd1;

  always_comb begin
    w_f_pc_wr    = 1'b0;
    w_f_id_wr    = 1'b0;
    w_f_id_flush = 1'b0;
    w_f_ack      = 1'b0;
    w_f_drop_nxt = r_drop_pending;
    if (!ifu_valid) begin
      w_f_id_flush = 1'b1;
    end else if (!r_drop_pending) begin
      w_f_pc_wr = 1'b1;
      w_f_id_wr = 1'b1;
      w_f_ack   = 1'b1;
    end else begin
      // Wrong-path fetch that was in flight at the branch: consume and discard
      w_f_id_flush = 1'b1;
      w_f_ack      = 1'b1;
      w_f_drop_nxt = 1'b0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_drop_nxt  = r_drop_pending;
    w_terr_nxt  = r_timeout_err;
    w_pc_wr     = 1'b0;
    w_id_wr     = 1'b0;
    w_ex_wr     = 1'b0;
    w_wb_wr     = 1'b0;
    w_id_flush  = 1'b0;
    w_ex_flush  = 1'b0;
    w_wb_flush  = 1'b0;
    w_ack       = 1'b0;
    w_lsu_req   = 1'b0;

    case (r_state)
      RUN: begin
        if (EX_MemRd || EX_MemWr) begin
          w_wb_flush  = 1'b1;
          w_state_nxt = MEM_REQ;
          w_cnt_nxt   = 16'd0;
        end else if (EX_BranchTaken) begin
          w_pc_wr    = 1'b1;
          w_id_flush = 1'b1;
          w_ex_flush = 1'b1;
          w_wb_wr    = 1'b1;
          w_ack      = ifu_valid;
          w_drop_nxt = ifu_busy;
        end else begin
          w_ex_wr    = 1'b1;
          w_wb_wr    = 1'b1;
          w_pc_wr    = w_f_pc_wr;
          w_id_wr    = w_f_id_wr;
          w_id_flush = w_f_id_flush;
          w_ack      = w_f_ack;
          w_drop_nxt = w_f_drop_nxt;
        end
      end

      MEM_REQ: begin
        w_lsu_req  = 1'b1;
        w_wb_flush = 1'b1;
        w_cnt_nxt  = w_cnt_inc;
        if (lsu_req_ready) begin
          w_state_nxt = MEM_RESP;
        end else if (w_cnt_last) begin
          w_state_nxt = HALT;
          w_terr_nxt  = 1'b1;
        end
      end

      MEM_RESP: begin
        if (lsu_resp_valid) begin
          w_ex_wr     = 1'b1;
          w_wb_wr     = 1'b1;
          w_pc_wr     = w_f_pc_wr;
          w_id_wr     = w_f_id_wr;
          w_id_flush  = w_f_id_flush;
          w_ack       = w_f_ack;
          w_drop_nxt  = w_f_drop_nxt;
          w_state_nxt = RUN;
        end else begin
          w_wb_flush = 1'b1;
          w_cnt_nxt  = w_cnt_inc;
          if (w_cnt_last) begin
            w_state_nxt = HALT;
            w_terr_nxt  = 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = HALT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= RUN;
      r_cnt          <= 16'd0;
      r_drop_pending <= 1'b0;
      r_timeout_err  <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_drop_pending <= w_drop_nxt;
      r_timeout_err  <= w_terr_nxt;
    end
  end

  // Reset gates every output combinationally, including an in-flight request
  assign PC_Wr         = rst_n & w_pc_wr;
  assign IDReg_Wr      = rst_n & w_id_wr;
  assign EXReg_Wr      = rst_n & w_ex_wr;
  assign WBReg_Wr      = rst_n & w_wb_wr;
  assign IDReg_Flush   = rst_n & w_id_flush;
  assign EXReg_Flush   = rst_n & w_ex_flush;
  assign WBReg_Flush   = rst_n & w_wb_flush;
  assign ifu_ack       = rst_n & w_ack;
  assign lsu_req_valid = rst_n & w_lsu_req;
  assign timeout_err   = rst_n & r_timeout_err;
  assign ctrl_state    = rst_n ? r_state : 2'd0;

endmodule
